osd_mam_bb_initiator: RTL and testbench



---
 rtl/osd_mam_bb_initiator.sv | 187 ++++++++++++++++++
 tb/tb_osd_mam_bb_initiator.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_mam_bb_initiator.sv
// osd_mam_bb_initiator
//
// Request-side initiator for the MAM blackbone memory interface. It takes one
// access command at a time, issues a single req handshake to the memory
// adapter, then streams beats. Write words go from the upstream source to the
// memory side, and read words go from the memory side to the downstream sink.
// When the last beat completes it pulses done for one cycle.
//
// Handshake rule, used on every channel (cmd, req, write, read, wdata, rdata):
// a transfer happens on a rising clk_i edge where valid and ready are both 1.
// A producer holds valid and its payload stable until that edge. It never
// withdraws valid. Ready may depend combinationally on valid.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   cmd_*                    access command (direction, address, burst, beats, strobe)
//   wdata_valid/wdata/_ready upstream write stream
//   rdata_valid/rdata/_ready downstream read stream
//   req_*                    memory request channel (registered)
//   write_*                  memory write channel (pass-through of wdata_*)
//   read_*                   memory read channel (pass-through to rdata_*)
//   busy                     1 whenever the FSM is not IDLE (state observation)
//   done, err                one-cycle completion pulse; err=1 marks a rejected command
//   beats_left               remaining beats of the current access
//
// DATA_WIDTH must be 8, 16 or 32.

module osd_mam_bb_initiator #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_burst,
    input  logic [12:0]             cmd_beats,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,

    input  logic                    wdata_valid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    wdata_ready,

    output logic                    rdata_valid,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    rdata_ready,

    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_we,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic                    req_burst,
    output logic [12:0]             req_beats,

    output logic                    write_valid,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH/8-1:0] write_strb,
    input  logic                    write_ready,

    input  logic                    read_valid,
    input  logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_ready,

    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [12:0]             beats_left
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    // Beat counter. It holds the effective beat count while in REQ, counts
    // down in WRITE/READ, and is 0 in IDLE/DONE, so it doubles as beats_left.
    logic [12:0] cnt;

    logic [12:0] eff_beats;
    assign eff_beats = cmd_burst ? cmd_beats : 13'd1;

    // Data channels are pure pass-through, gated by state so that nothing
    // leaks onto the memory or sink side outside the data phase.
    assign cmd_ready   = (state == IDLE);
    assign write_valid = (state == WRITE) && wdata_valid;
    assign write_data  = wdata;
    assign wdata_ready = (state == WRITE) && write_ready;
    assign rdata_valid = (state == READ) && read_valid;
    assign rdata       = read_data;
    assign read_ready  = (state == READ) && rdata_ready;
    assign beats_left  = cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= 13'd0;
            req_valid  <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_burst  <= 1'b0;
            req_beats  <= 13'd0;
            write_strb <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // done/err are pulses that are only raised on entry to DONE.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        busy <= 1'b1;
                        if (cmd_burst && (cmd_beats == 13'd0)) begin
                            // A zero-length burst is rejected without
                            // touching the memory side.
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state      <= REQ;
                            req_valid  <= 1'b1;
                            req_we     <= cmd_we;
                            req_addr   <= cmd_addr;
                            req_burst  <= cmd_burst;
                            req_beats  <= eff_beats;
                            cnt        <= eff_beats;
                            write_strb <= cmd_burst ? '1 : cmd_strb;
                        end
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        cnt       <= req_beats;
                        state     <= req_we ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wdata_valid && write_ready) begin
                        if (cnt == 13'd1) begin
                            state <= DONE;
                            done  <= 1'b1;
                            cnt   <= 13'd0;
                        end else begin
                            cnt <= cnt - 13'd1;
                        end
                    end
                end
                READ: begin
                    if (read_valid && rdata_ready) begin
                        if (cnt == 13'd1) begin
                            state <= DONE;
                            done  <= 1'b1;
                            cnt   <= 13'd0;
                        end else begin
                            cnt <= cnt - 13'd1;
                        end
                    end
                end
                DONE: begin
                    // Return the request fields to 0 so IDLE presents a
                    // quiet interface.
                    state      <= IDLE;
                    busy       <= 1'b0;
                    req_we     <= 1'b0;
                    req_addr   <= '0;
                    req_burst  <= 1'b0;
                    req_beats  <= 13'd0;
                    write_strb <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osd_mam_bb_initiator.sv
module tb_osd_mam_bb_initiator;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic          cmd_valid = 0, cmd_we = 0, cmd_burst = 0;
    logic [AW-1:0] cmd_addr = '0;
    logic [12:0]   cmd_beats = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic          cmd_ready;
    logic          wdata_valid = 0;
    logic [DW-1:0] wdata = '0;
    logic          wdata_ready;
    logic          rdata_valid;
    logic [DW-1:0] rdata;
    logic          rdata_ready = 0;
    logic          req_valid, req_we, req_burst;
    logic          req_ready = 0;
    logic [AW-1:0] req_addr;
    logic [12:0]   req_beats;
    logic          write_valid;
    logic [DW-1:0] write_data;
    logic [SW-1:0] write_strb;
    logic          write_ready = 0;
    logic          read_valid = 0;
    logic [DW-1:0] read_data = '0;
    logic          read_ready;
    logic          busy, done, err;
    logic [12:0]   beats_left;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    osd_mam_bb_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_beats(cmd_beats),
        .cmd_strb(cmd_strb),
        .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_ready(rdata_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_data(write_data),
        .write_strb(write_strb), .write_ready(write_ready),
        .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready),
        .busy(busy), .done(done), .err(err), .beats_left(beats_left)
    );

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a falling edge; the DUT is sampled
    // there, half a period away from the active edge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic issue_cmd(input logic we, input logic [AW-1:0] addr,
                             input logic burst, input logic [12:0] beats,
                             input logic [SW-1:0] strb);
        cmd_valid = 1; cmd_we = we; cmd_addr = addr;
        cmd_burst = burst; cmd_beats = beats; cmd_strb = strb;
        tick();
        cmd_valid = 0;
        #1;
    endtask

    task automatic grant_req();
        int n;
        n = 0;
        while (!req_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!req_valid) begin
            errors++;
            $display("FAIL grant_timeout: req_valid=%0b expected 1 within 10 cycles", req_valid);
        end
        req_ready = 1;
        tick();
        req_ready = 0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1;
        tick(); tick();
        checks++;
        if ({cmd_ready, req_valid, busy, done, err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: {cmd_ready,req_valid,busy,done,err}=%b expected 10000",
                     {cmd_ready, req_valid, busy, done, err});
        end
        checks++;
        if ({req_we, req_burst, req_addr, req_beats, write_strb, beats_left} !== '0) begin
            errors++;
            $display("FAIL reset_fields: addr=%h beats=%0d strb=%b left=%0d expected all 0",
                     req_addr, req_beats, write_strb, beats_left);
        end
        rst_i = 0;
        #1;
    endtask

    task automatic test_single_write();
        issue_cmd(1'b1, 32'h100, 1'b0, 13'd5, 2'b01);
        checks++;
        if ({req_valid, req_we, req_burst, cmd_ready, busy} !== 5'b11001) begin
            errors++;
            $display("FAIL sw_req_ctrl: {req_valid,we,burst,cmd_ready,busy}=%b expected 11001",
                     {req_valid, req_we, req_burst, cmd_ready, busy});
        end
        checks++;
        if (req_addr !== 32'h100 || req_beats !== 13'd1 || beats_left !== 13'd1) begin
            errors++;
            $display("FAIL sw_req_fields: addr=%h beats=%0d left=%0d expected 100/1/1",
                     req_addr, req_beats, beats_left);
        end
        grant_req();
        write_ready = 1; wdata_valid = 1; wdata = 16'hBEEF;
        #1;
        checks++;
        if ({write_valid, wdata_ready, req_valid} !== 3'b110 || write_data !== 16'hBEEF ||
            write_strb !== 2'b01) begin
            errors++;
            $display("FAIL sw_data: wv=%b wr=%b rv=%b data=%h strb=%b expected 1,1,0,beef,01",
                     write_valid, wdata_ready, req_valid, write_data, write_strb);
        end
        tick();
        wdata_valid = 0;
        #1;
        checks++;
        if ({done, err, write_valid, cmd_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL sw_done: {done,err,write_valid,cmd_ready}=%b expected 1000",
                     {done, err, write_valid, cmd_ready});
        end
        tick();
        checks++;
        if ({done, cmd_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL sw_idle: {done,cmd_ready,busy}=%b expected 010", {done, cmd_ready, busy});
        end
    endtask

    task automatic test_burst_write();
        int xfers;
        int n;
        logic [DW-1:0] exp_w;
        xfers = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h1000 + 16'(i));
        issue_cmd(1'b1, 32'h300, 1'b1, 13'd4, 2'b00);
        checks++;
        if (req_beats !== 13'd4 || req_burst !== 1'b1 || beats_left !== 13'd4) begin
            errors++;
            $display("FAIL bw_req: beats=%0d burst=%b left=%0d expected 4/1/4",
                     req_beats, req_burst, beats_left);
        end
        grant_req();
        write_ready = 1;
        n = 0;
        while (!done && n < 20) begin
            wdata_valid = (n % 2 == 0);
            wdata = 16'h1000 + 16'(xfers);
            #1;
            if (write_valid && write_ready) begin
                exp_w = exp_q.pop_front();
                checks++;
                if (write_data !== exp_w || write_strb !== 2'b11 ||
                    beats_left !== 13'(4 - xfers)) begin
                    errors++;
                    $display("FAIL bw_beat%0d: data=%h strb=%b left=%0d expected %h/11/%0d",
                             xfers, write_data, write_strb, beats_left, exp_w, 4 - xfers);
                end
                xfers++;
            end
            tick();
            n++;
        end
        wdata_valid = 0;
        write_ready = 0;
        #1;
        checks++;
        if (xfers !== 4 || done !== 1'b1 || err !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bw_count: xfers=%0d done=%b err=%b expected 4 transfers then done",
                     xfers, done, err);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_burst_read();
        int words;
        int n;
        logic [DW-1:0] exp_r;
        words = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back(16'hA000 + 16'(i));
        issue_cmd(1'b0, 32'h2000, 1'b1, 13'd3, 2'b00);
        checks++;
        if (req_addr !== 32'h2000 || req_we !== 1'b0 || req_beats !== 13'd3) begin
            errors++;
            $display("FAIL br_req: addr=%h we=%b beats=%0d expected 2000/0/3",
                     req_addr, req_we, req_beats);
        end
        grant_req();
        n = 0;
        while (!done && n < 20) begin
            read_valid = 1;
            read_data = 16'hA000 + 16'(words);
            rdata_ready = !(n == 1 || n == 2);
            #1;
            checks++;
            if (rdata !== read_data || read_ready !== rdata_ready || rdata_valid !== 1'b1) begin
                errors++;
                $display("FAIL br_pass%0d: rdata=%h rr=%b rv=%b expected %h/%b/1",
                         n, rdata, read_ready, rdata_valid, read_data, rdata_ready);
            end
            if (rdata_valid && rdata_ready) begin
                exp_r = exp_q.pop_front();
                checks++;
                if (rdata !== exp_r) begin
                    errors++;
                    $display("FAIL br_word%0d: rdata=%h expected %h", words, rdata, exp_r);
                end
                words++;
            end
            tick();
            n++;
        end
        read_valid = 0; rdata_ready = 0;
        #1;
        checks++;
        if (words !== 3 || done !== 1'b1 || rdata_valid !== 1'b0 || read_ready !== 1'b0) begin
            errors++;
            $display("FAIL br_end: words=%0d done=%b rv=%b rr=%b expected 3/1/0/0",
                     words, done, rdata_valid, read_ready);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_req_backpressure();
        issue_cmd(1'b0, 32'h55AA, 1'b0, 13'd0, 2'b11);
        // A second command presented while busy must not be taken.
        cmd_valid = 1; cmd_we = 1; cmd_addr = 32'hFFFF; cmd_burst = 1; cmd_beats = 13'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({req_valid, req_we, req_burst, cmd_ready} !== 4'b1000 ||
                req_addr !== 32'h55AA || req_beats !== 13'd1) begin
                errors++;
                $display("FAIL bp_hold%0d: rv=%b we=%b burst=%b cr=%b addr=%h beats=%0d",
                         i, req_valid, req_we, req_burst, cmd_ready, req_addr, req_beats);
            end
            tick();
        end
        cmd_valid = 0;
        grant_req();
        read_valid = 1; read_data = 16'h1234; rdata_ready = 1;
        tick();
        read_valid = 0; rdata_ready = 0;
        #1;
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: done=%b err=%b expected 1/0", done, err);
        end
        tick();
    endtask

    task automatic test_error();
        int lat;
        logic saw_req;
        lat = 0;
        saw_req = 0;
        issue_cmd(1'b1, 32'h800, 1'b1, 13'd0, 2'b11);
        lat = 1;
        while (!done && lat < 4) begin
            saw_req |= req_valid;
            tick();
            lat++;
        end
        saw_req |= req_valid;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || lat > 2 || saw_req !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: done=%b err=%b latency=%0d req_seen=%b expected 1/1/<=2/0",
                     done, err, lat, saw_req);
        end
        tick();
        checks++;
        if ({done, err, cmd_ready, req_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL err_after: {done,err,cmd_ready,req_valid}=%b expected 0010",
                     {done, err, cmd_ready, req_valid});
        end
    endtask

    task automatic test_reset_mid_burst();
        int xfers;
        xfers = 0;
        issue_cmd(1'b1, 32'h400, 1'b1, 13'd5, 2'b00);
        grant_req();
        write_ready = 1; wdata_valid = 1;
        for (int i = 0; i < 2; i++) begin
            wdata = 16'h5000 + 16'(i);
            #1;
            if (write_valid) xfers++;
            tick();
        end
        checks++;
        if (beats_left !== 13'd3 || xfers !== 2) begin
            errors++;
            $display("FAIL rm_progress: left=%0d xfers=%0d expected 3/2", beats_left, xfers);
        end
        rst_i = 1;
        tick();
        #1;
        checks++;
        if ({cmd_ready, write_valid, wdata_ready, done, busy, req_valid} !== 6'b100000 ||
            beats_left !== 13'd0) begin
            errors++;
            $display("FAIL rm_reset: {cr,wv,wr,done,busy,rv}=%b left=%0d expected 100000/0",
                     {cmd_ready, write_valid, wdata_ready, done, busy, req_valid}, beats_left);
        end
        rst_i = 0; wdata_valid = 0; write_ready = 0;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rm_nodone: done=%b expected 0", done);
        end
        issue_cmd(1'b0, 32'h40, 1'b0, 13'd0, 2'b00);
        checks++;
        if (req_addr !== 32'h40 || req_we !== 1'b0 || req_valid !== 1'b1) begin
            errors++;
            $display("FAIL rm_req: addr=%h we=%b rv=%b expected 40/0/1", req_addr, req_we, req_valid);
        end
        grant_req();
        read_valid = 1; read_data = 16'h7777; rdata_ready = 1;
        #1;
        checks++;
        if (rdata !== 16'h7777 || rdata_valid !== 1'b1) begin
            errors++;
            $display("FAIL rm_rdata: rdata=%h rv=%b expected 7777/1", rdata, rdata_valid);
        end
        tick();
        read_valid = 0; rdata_ready = 0;
        #1;
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rm_done: done=%b err=%b expected 1/0", done, err);
        end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk_i);
        test_reset();
        test_single_write();
        test_burst_write();
        test_burst_read();
        test_req_backpressure();
        test_error();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
